fetch_pc_unit: RTL and testbench

- Fetch stage directly downstream of branch_ctrlr.
- Owns the architectural PC register and drives it back to branch_ctrlr as w_pc_32; each cycle it consumes branch_ctrlr's w_pc_out_32 as the next PC.
- Issues in-order instruction-memory reads with a valid/ready handshake and buffers returned words in a small queue.
- Presents {pc, instruction} to decode with a valid/ready handshake; on a taken branch/jump it flushes all wrong-path work.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_pc_checker.sv | 27 ++
 rtl/fetch_queue.sv | 67 ++++++
 rtl/fetch_pc_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: state encoding, reset PC,
// the NOP word and the {pc, insn} queue entry layout.
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_checker.sv
// Protocol checks for the fetch stage: no unsolicited responses, no push into
// a full instruction queue, no pop from an empty one.
module fetch_pc_checker #(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input logic          clock,
    input logic          reset,
    input logic          rsp_valid,
    input logic [CW-1:0] outstanding,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] occupancy
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    a_rsp_without_request: assert property (@(posedge clock) disable iff (reset)
        !(rsp_valid && (outstanding == '0)));

    a_push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && (occupancy == FULL_CNT)));

    a_pop_when_empty: assert property (@(posedge clock) disable iff (reset)
        !(pop && (occupancy == '0)));

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO with a flush that discards all contents
// (including any same-cycle push/pop) and an occupancy count output.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int AW                = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current fill level; a full queue may still push when it pops.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale contents are never observed because consumers mask by count.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order imem reads, queues
// returned words with their PCs for decode, and flushes wrong-path work on redirect.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] w_next_pc_32,
    input  logic        w_redirect,
    output logic [31:0] w_pc_32,
    output logic        w_imem_req_valid,
    input  logic        w_imem_req_ready,
    output logic [31:0] w_imem_addr_32,
    input  logic        w_imem_rsp_valid,
    input  logic [31:0] w_imem_rsp_data_32,
    output logic        w_dec_valid,
    input  logic        w_dec_ready,
    output logic [31:0] w_dec_insn_32,
    output logic [31:0] w_dec_pc_32
);

    localparam int CW                  = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    fetch_state_e  state_r;
    logic [31:0]   pc_r;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] drop_next_s;
    logic [CW-1:0] outstanding_s;
    logic [CW-1:0] occupancy_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   tag_pc_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_entry_s;

    // Credit rule: in-flight requests plus queued words never exceed the queue depth,
    // so every response is guaranteed a slot.
    always_comb begin
        if (reset) begin
            req_valid_s = 1'b0;
        end else begin
            req_valid_s = (state_r == FETCH) && !w_redirect &&
                          (({1'b0, outstanding_s} + {1'b0, occupancy_s}) < DEPTH_EXT);
        end
    end

    // Handshake qualification; a redirect kills any same-cycle push or pop.
    always_comb begin
        req_fire_s   = req_valid_s && w_imem_req_ready;
        push_s       = w_imem_rsp_valid && (drop_r == '0) && !w_redirect;
        pop_s        = (occupancy_s != '0) && w_dec_ready && !w_redirect;
        push_entry_s = '{pc: tag_pc_s, insn: w_imem_rsp_data_32};
        if (w_imem_rsp_valid) begin
            drop_next_s = outstanding_s - CNT_ONE;
        end else begin
            drop_next_s = outstanding_s;
        end
    end

    // Address tags of issued requests; its occupancy is the outstanding-request count.
    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (1'b0),
        .push      (req_fire_s),
        .push_data (pc_r),
        .pop       (w_imem_rsp_valid),
        .head_data (tag_pc_s),
        .count     (outstanding_s)
    );

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_insn_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (w_redirect),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .count     (occupancy_s)
    );

    // PC, stale-response drop counter and FETCH/FLUSH state.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            drop_r  <= '0;
            state_r <= FETCH;
        end else if (w_redirect) begin
            pc_r    <= w_next_pc_32;
            drop_r  <= drop_next_s;
            state_r <= (drop_next_s != '0) ? FLUSH : FETCH;
        end else begin
            if (req_fire_s) begin
                pc_r <= w_next_pc_32;
            end
            if (w_imem_rsp_valid && (drop_r != '0)) begin
                drop_r <= drop_r - CNT_ONE;
            end
            case (state_r)
                FETCH: state_r <= FETCH;
                FLUSH: begin
                    if ((drop_r == '0) || (w_imem_rsp_valid && (drop_r == CNT_ONE))) begin
                        state_r <= FETCH;
                    end
                end
                default: state_r <= FETCH;
            endcase
        end
    end

    assign w_pc_32          = pc_r;
    assign w_imem_addr_32   = pc_r;
    assign w_imem_req_valid = req_valid_s;
    assign w_dec_valid      = (occupancy_s != '0);
    assign w_dec_insn_32    = w_dec_valid ? head_entry_s.insn : NOP_INSN;
    assign w_dec_pc_32      = w_dec_valid ? head_entry_s.pc   : 32'h0000_0000;

    fetch_pc_checker #(
        .DEPTH (DEPTH)
    ) u_checker (
        .clock       (clock),
        .reset       (reset),
        .rsp_valid   (w_imem_rsp_valid),
        .outstanding (outstanding_s),
        .push        (push_s),
        .pop         (pop_s),
        .occupancy   (occupancy_s)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: a latency-randomized in-order memory and a
// transaction-level model (outstanding list with stale marks, decode queue).
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0100_0000;
    localparam logic [31:0] MASK   = 32'hFFFF_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] w_next_pc_32;
    logic        w_redirect;
    logic [31:0] w_pc_32;
    logic        w_imem_req_valid;
    logic        w_imem_req_ready;
    logic [31:0] w_imem_addr_32;
    logic        w_imem_rsp_valid;
    logic [31:0] w_imem_rsp_data_32;
    logic        w_dec_valid;
    logic        w_dec_ready;
    logic [31:0] w_dec_insn_32;
    logic [31:0] w_dec_pc_32;

    always #5 clock = ~clock;

    fetch_pc_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .w_next_pc_32       (w_next_pc_32),
        .w_redirect         (w_redirect),
        .w_pc_32            (w_pc_32),
        .w_imem_req_valid   (w_imem_req_valid),
        .w_imem_req_ready   (w_imem_req_ready),
        .w_imem_addr_32     (w_imem_addr_32),
        .w_imem_rsp_valid   (w_imem_rsp_valid),
        .w_imem_rsp_data_32 (w_imem_rsp_data_32),
        .w_dec_valid        (w_dec_valid),
        .w_dec_ready        (w_dec_ready),
        .w_dec_insn_32      (w_dec_insn_32),
        .w_dec_pc_32        (w_dec_pc_32)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    endtask

    // environment: memory with pending requests and due cycles
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          p_req_ready = 100, p_dec_ready = 100, p_rsp = 100;

    // reference model
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    logic [31:0] m_out_addr[$];
    bit          m_out_stale[$];
    logic [31:0] exp_dec_pc;

    // observation
    logic [31:0] dec_log_pc[$];
    logic [31:0] dec_log_insn[$];
    int          n_fire = 0;
    logic        s_req, s_dec_valid;
    logic [31:0] s_pc;
    bit          redir_on_rsp = 0;
    logic [31:0] redir_tgt = 32'h0;

    task automatic cycle(input bit rst, input bit redir, input logic [31:0] tgt);
        bit          rsp, flushing, exp_req, fire_dut, fire_m, pop_m, st;
        logic [31:0] rdata, oa;
        rsp = 1'b0;
        if (!rst && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && $urandom_range(99) < p_rsp)
            rsp = 1'b1;
        w_dec_ready      = ($urandom_range(99) < p_dec_ready);
        w_imem_req_ready = ($urandom_range(99) < p_req_ready);
        if (redir_on_rsp && !rst && rsp && w_dec_ready && m_q.size() > 0) begin
            redir = 1'b1;
            tgt = redir_tgt;
            redir_on_rsp = 1'b0;
        end
        rdata              = rsp ? (mem_addr_q[0] ^ MASK) : $urandom;
        reset              = rst;
        w_redirect         = redir;
        w_next_pc_32       = redir ? tgt : m_pc + 32'd4;
        w_imem_rsp_valid   = rsp;
        w_imem_rsp_data_32 = rdata;
        #1;
        flushing = 1'b0;
        foreach (m_out_stale[i]) if (m_out_stale[i]) flushing = 1'b1;
        exp_req = !rst && !flushing && !redir && (m_out_addr.size() + m_q.size() < DEPTH);
        s_req = w_imem_req_valid;
        s_dec_valid = w_dec_valid;
        s_pc = w_pc_32;
        check_eq("req_valid", w_imem_req_valid, exp_req);
        if (!rst) begin
            check_eq("pc", w_pc_32, m_pc);
            check_eq("addr", w_imem_addr_32, m_pc);
            check_eq("dec_valid", w_dec_valid, m_q.size() > 0);
            check_eq("dec_pc", w_dec_pc_32, (m_q.size() > 0) ? m_q[0][63:32] : 32'h0);
            check_eq("dec_insn", w_dec_insn_32, (m_q.size() > 0) ? m_q[0][31:0] : NOP_INSN);
            if (w_dec_valid && w_dec_ready && !redir) begin
                check_eq("dec_seq", w_dec_pc_32, exp_dec_pc);
                exp_dec_pc = exp_dec_pc + 32'd4;
                dec_log_pc.push_back(w_dec_pc_32);
                dec_log_insn.push_back(w_dec_insn_32);
            end
        end
        fire_dut = !rst && w_imem_req_valid && w_imem_req_ready;
        fire_m   = exp_req && w_imem_req_ready;
        pop_m    = !rst && !redir && m_q.size() > 0 && w_dec_ready;
        if (rst) begin
            m_pc = RST_PC;
            exp_dec_pc = RST_PC;
            m_q.delete();
            m_out_addr.delete();
            m_out_stale.delete();
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (pop_m) void'(m_q.pop_front());
            if (rsp) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
                if (m_out_addr.size() > 0) begin
                    oa = m_out_addr.pop_front();
                    st = m_out_stale.pop_front();
                    if (!st && !redir) m_q.push_back({oa, rdata});
                end
            end
            if (redir) begin
                m_q.delete();
                foreach (m_out_stale[i]) m_out_stale[i] = 1'b1;
                m_pc = tgt;
                exp_dec_pc = tgt;
                dec_log_pc.delete();
                dec_log_insn.delete();
            end else if (fire_m) begin
                m_out_addr.push_back(m_pc);
                m_out_stale.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
            if (fire_dut) begin
                n_fire++;
                mem_addr_q.push_back(w_imem_addr_32);
                mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        dec_log_pc.delete();
        dec_log_insn.delete();
    endtask

    task automatic check_first_three(input string tag, input logic [31:0] base);
        logic [31:0] p, d;
        for (int i = 0; i < 3; i++) begin
            p = (i < dec_log_pc.size()) ? dec_log_pc[i] : 32'hDEAD_BEEF;
            d = (i < dec_log_insn.size()) ? dec_log_insn[i] : 32'hDEAD_BEEF;
            check_eq({tag, "_pc"}, p, base + 32'(4 * i));
            check_eq({tag, "_insn"}, d, (base + 32'(4 * i)) ^ MASK);
        end
    endtask

    task automatic wait_outstanding2(input string tag);
        for (int i = 0; i < 40 && m_out_addr.size() != 2; i++) run(1);
        check_eq(tag, m_out_addr.size(), 32'd2);
    endtask

    initial begin
        reset = 1'b1; w_redirect = 1'b0; w_next_pc_32 = 32'h0;
        w_imem_req_ready = 1'b0; w_imem_rsp_valid = 1'b0; w_imem_rsp_data_32 = 32'h0;
        w_dec_ready = 1'b0;
        m_pc = RST_PC;
        exp_dec_pc = RST_PC;
        #1;

        // reset then sequential run, 1-cycle memory
        do_reset();
        check_eq("rst_pc", w_pc_32, RST_PC);
        check_eq("rst_dec_valid", w_dec_valid, 32'd0);
        check_eq("rst_dec_insn", w_dec_insn_32, 32'd0);
        check_eq("rst_dec_pc", w_dec_pc_32, 32'd0);
        run(12);
        check_first_three("seq", RST_PC);

        // decode backpressure
        p_dec_ready = 0;
        n_fire = 0;
        run(10);
        check_eq("bp_fires_le_depth", (n_fire <= DEPTH), 32'd1);
        check_eq("bp_req_low", s_req, 32'd0);
        p_dec_ready = 100;
        run(20);

        // redirect with two outstanding, 3-cycle memory
        do_reset();
        lat_min = 3; lat_max = 3;
        wait_outstanding2("wait_out2_a");
        cycle(1'b0, 1'b1, 32'h0100_0100);
        run(1);
        check_eq("flush_req_low", s_req, 32'd0);
        run(20);
        check_first_three("redir", 32'h0100_0100);

        // redirect coinciding with a response and a decode pop
        do_reset();
        lat_min = 2; lat_max = 2;
        redir_tgt = 32'h0100_0200;
        redir_on_rsp = 1'b1;
        for (int i = 0; i < 40 && redir_on_rsp; i++) run(1);
        check_eq("redir_rsp_pop_hit", redir_on_rsp, 32'd0);
        run(1);
        check_eq("redir_q_empty", s_dec_valid, 32'd0);
        run(20);
        check_first_three("redir_rsp", 32'h0100_0200);

        // back-to-back redirects while flushing
        do_reset();
        lat_min = 3; lat_max = 3;
        wait_outstanding2("wait_out2_b");
        cycle(1'b0, 1'b1, 32'h0000_2000);
        cycle(1'b0, 1'b1, 32'h0000_3000);
        run(25);
        check_first_three("b2b", 32'h0000_3000);

        // reset in the middle of a flush
        do_reset();
        wait_outstanding2("wait_out2_c");
        cycle(1'b0, 1'b1, 32'h0100_0400);
        cycle(1'b1, 1'b0, 32'h0);
        run(1);
        check_eq("midflush_rst_pc", s_pc, RST_PC);
        check_eq("midflush_rst_dec", s_dec_valid, 32'd0);
        lat_min = 1; lat_max = 1;
        do_reset();
        run(12);
        check_first_three("post_rst", RST_PC);

        // randomized traffic with redirects, wrap-around targets and rare resets
        for (int blk = 0; blk < 30; blk++) begin
            lat_min     = 1;
            lat_max     = int'($urandom_range(4, 1));
            p_req_ready = int'($urandom_range(100, 30));
            p_dec_ready = int'($urandom_range(100, 20));
            p_rsp       = int'($urandom_range(100, 40));
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(999) < 4) cycle(1'b1, 1'b0, 32'h0);
                else if ($urandom_range(99) < 6)
                    cycle(1'b0, 1'b1, ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC));
                else cycle(1'b0, 1'b0, 32'h0);
            end
        end
        p_rsp = 100; p_dec_ready = 100;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
